alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Command-side driver for the 4-bit combinational ALU.
- Buffers operation commands in a small FIFO and drives operands and selector onto the ALU inputs.
- Waits a fixed settle time, then captures the ALU result and returns it on a valid/ready result channel.
- Sits between a command producer (test controller or future datapath sequencer) and the ALU instance.

Parameters:
DEPTH, 4, command FIFO depth in entries; must be a power of 2 and at least 2
SETTLE, 1, cycles operands are held on the ALU before the result is sampled; must be at least 1

Ports:
iClk  in  1  single clock, rising edge
iRst  in  1  synchronous, active-high reset
iCmdValid  in  1  command valid
oCmdReady  out  1  command FIFO not full
iCmdOp  in  3  ALU selector: 0 add, 1 sub, 2 and, 3 or, 4 xor; 5-7 illegal
iCmdA  in  4  operand 1
iCmdB  in  4  operand 2
oAluNibble1  out  4  to ALU iNibble1
oAluNibble2  out  4  to ALU iNibble2
oAluSelector  out  3  to ALU selector
iAluResult  in  4  from ALU result
oResValid  out  1  result valid
iResReady  in  1  result accepted
oResult  out  4  captured result
oResOp  out  3  op that produced oResult
oResErr  out  1  result came from an illegal op
oBusy  out  1  FSM not in IDLE, or FIFO non-empty
oCount  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (synchronous, iRst high at a rising edge):
  - Empties the FIFO and sets state to IDLE.
  - Drives every output to 0, except oCmdReady, which is 1 after reset.
  - Asserting reset mid-operation discards the in-flight and queued commands with no partial result.
- Command push:
  - Occurs when iCmdValid && oCmdReady at the edge.
  - oCmdReady = (oCount != DEPTH), combinational from the count.
  - There is no bypass: a command pushed into an empty FIFO is not popped in the same cycle.
- FIFO pointers wrap modulo DEPTH. Push and pop in the same cycle leaves oCount unchanged.
- FSM states:
  - IDLE:
    - FIFO non-empty: pop the head.
    - Legal op: load oAluNibble1/oAluNibble2/oAluSelector and oResOp, then go to DRIVE with the settle counter = SETTLE-1.
    - Illegal op: set oResult=0, oResErr=1, oResOp=op, leave the ALU outputs unchanged, then go to HOLD.
  - DRIVE:
    - ALU outputs stay stable.
    - Counter nonzero: decrement it.
    - Counter zero: register iAluResult into oResult, clear oResErr, then go to HOLD.
  - HOLD:
    - oResValid=1; oResult, oResOp and oResErr are stable.
    - On iResReady: drop oResValid at that edge and go to IDLE.
- Latency, with the push in cycle 0 into an empty FIFO and no stall:
  - Pop at the end of cycle 1.
  - Legal op: oResValid high in cycle 2+SETTLE (cycle 3 for the default).
  - Illegal op: oResValid high in cycle 2.
- Throughput: at most one result per SETTLE+2 cycles, because IDLE always occupies one cycle.
- ALU output registers hold their last driven values outside DRIVE and are never X after reset.
- Result arithmetic belongs to the ALU; this block does no arithmetic of its own. The ALU's 4-bit sub wraps modulo 16.
- iResReady outside HOLD is ignored. The FIFO continues accepting commands during DRIVE and HOLD.

Optional Feature:
- Macro: ALU_SEQ_ZERO_FLAG_EN.
- When defined:
  - Adds output oResZero (1 bit), registered alongside oResult.
  - Set to 1 when the captured result equals 0 (illegal ops included).
  - Resets to 0 and is valid only while oResValid is high.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Bench setup: the ALU is instantiated and connected to this block; DEPTH=4, SETTLE=1.
- Push op0 A=5 B=7 in cycle 0, iResReady=1 -> oResValid in cycle 3, oResult=12, oResOp=0, oResErr=0.
- Push op1 A=5 B=10 -> oResult=4'hB (wrap), then op2 A=4'hC B=4'hA -> 4'h8, op4 A=4'hF B=4'h5 -> 4'hA, in push order.
- iResReady=0, push 5 commands back-to-back -> the first is popped, oCmdReady drops once oCount=4 with one result held; release ready -> all results return in order and none is lost.
- Push op6 A=3 B=3 -> oResValid in cycle 2, oResult=0, oResErr=1, ALU outputs unchanged. With ALU_SEQ_ZERO_FLAG_EN: oResZero=1.
- Hold iResReady=0 for 10 cycles in HOLD -> oResult and oResOp stable and oResValid stays 1; the next command is not popped until the handshake.
- Assert iRst during DRIVE with 2 commands queued -> next cycle oCount=0, oResValid=0, ALU outputs 0, oCmdReady=1, and no result appears afterwards.

Source files
------------

// File: rtl/alu_op_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : Command-side driver for the 4-bit combinational ALU. Queues
//            commands in a small FIFO, drives operands/selector onto the ALU,
//            waits SETTLE cycles, captures the result and returns it on a
//            valid/ready result channel.
// Options  : ALU_SEQ_ZERO_FLAG_EN adds oResZero (captured result == 0).
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iCmdValid,
  output logic                     oCmdReady,
  input  logic [2:0]               iCmdOp,
  input  logic [3:0]               iCmdA,
  input  logic [3:0]               iCmdB,
  output logic [3:0]               oAluNibble1,
  output logic [3:0]               oAluNibble2,
  output logic [2:0]               oAluSelector,
  input  logic [3:0]               iAluResult,
  output logic                     oResValid,
  input  logic                     iResReady,
  output logic [3:0]               oResult,
  output logic [2:0]               oResOp,
  output logic                     oResErr,
`ifdef ALU_SEQ_ZERO_FLAG_EN
  output logic                     oResZero,
`endif
  output logic                     oBusy,
  output logic [$clog2(DEPTH):0]   oCount
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [c_AW:0]   c_FULL        = (c_AW + 1)'(DEPTH);
  localparam logic [c_AW:0]   c_CNT_ONE     = (c_AW + 1)'(1);
  localparam logic [c_AW-1:0] c_PTR_ONE     = c_AW'(1);
  localparam logic [c_SW-1:0] c_SETTLE_LOAD = c_SW'(SETTLE - 1);
  localparam logic [c_SW-1:0] c_SETTLE_ONE  = c_SW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]      r_mem_op [DEPTH];
  logic [3:0]      r_mem_a  [DEPTH];
  logic [3:0]      r_mem_b  [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;
  logic [c_SW-1:0] r_settle;

  logic       w_push;
  logic       w_pop;
  logic       w_load;
  logic       w_load_err;
  logic       w_capture;
  logic       w_settle_dec;
  logic [2:0] w_head_op;
  logic [3:0] w_head_a;
  logic [3:0] w_head_b;
  logic       w_head_legal;

  assign oCmdReady    = (r_count != c_FULL);
  assign oCount       = r_count;
  assign oBusy        = (r_state != ST_IDLE) || (r_count != '0);
  assign oResValid    = (r_state == ST_HOLD);
  assign w_push       = iCmdValid && oCmdReady;
  assign w_head_op    = r_mem_op[r_rd_ptr];
  assign w_head_a     = r_mem_a[r_rd_ptr];
  assign w_head_b     = r_mem_b[r_rd_ptr];
  assign w_head_legal = (w_head_op <= 3'd4);

  // Command storage; contents are only read after being written, so no reset.
  always_ff @(posedge iClk) begin
    if (w_push) begin
      r_mem_op[r_wr_ptr] <= iCmdOp;
      r_mem_a[r_wr_ptr]  <= iCmdA;
      r_mem_b[r_wr_ptr]  <= iCmdB;
    end
  end

  // FSM state register.
  always_ff @(posedge iClk) begin
    if (iRst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state and datapath strobes; IDLE always costs one cycle (no bypass).
  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_load_err   = 1'b0;
    w_capture    = 1'b0;
    w_settle_dec = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_count != '0) begin
          w_pop = 1'b1;
          if (w_head_legal) begin
            w_load      = 1'b1;
            w_state_nxt = ST_DRIVE;
          end else begin
            w_load_err  = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end
      end
      ST_DRIVE: begin
        if (r_settle != '0) begin
          w_settle_dec = 1'b1;
        end else begin
          w_capture   = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (iResReady) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + c_CNT_ONE;
      else if (!w_push && w_pop) r_count <= r_count - c_CNT_ONE;
    end
  end

  // ALU drive registers, settle counter and captured result.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oAluNibble1  <= '0;
      oAluNibble2  <= '0;
      oAluSelector <= '0;
      oResult      <= '0;
      oResOp       <= '0;
      oResErr      <= 1'b0;
      r_settle     <= '0;
    end else begin
      if (w_load) begin
        oAluNibble1  <= w_head_a;
        oAluNibble2  <= w_head_b;
        oAluSelector <= w_head_op;
        oResOp       <= w_head_op;
        r_settle     <= c_SETTLE_LOAD;
      end
      if (w_load_err) begin
        oResult <= '0;
        oResErr <= 1'b1;
        oResOp  <= w_head_op;
      end
      if (w_settle_dec) r_settle <= r_settle - c_SETTLE_ONE;
      if (w_capture) begin
        oResult <= iAluResult;
        oResErr <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_ZERO_FLAG_EN
  // Zero flag tracks whatever value is captured into oResult.
  always_ff @(posedge iClk) begin
    if (iRst)            oResZero <= 1'b0;
    else if (w_load_err) oResZero <= 1'b1;
    else if (w_capture)  oResZero <= (iAluResult == 4'd0);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_alu_op_sequencer
// Purpose  : Scoreboard bench for alu_op_sequencer with an ALU model attached.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 1;

  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, res_valid, res_ready, res_err, busy;
  logic [2:0] cmd_op, alu_sel, res_op;
  logic [3:0] cmd_a, cmd_b, alu_n1, alu_n2, alu_res, result;
  logic [$clog2(DEPTH):0] count;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic res_zero;
`endif

  typedef struct {
    logic [2:0] op;
    logic [3:0] res;
    logic       err;
    logic [3:0] sa;
    logic [3:0] sb;
    logic [2:0] ssel;
  } exp_t;

  exp_t exp_q[$];
  logic [3:0] mdl_a = '0, mdl_b = '0;
  logic [2:0] mdl_sel = '0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .iClk(clk), .iRst(rst),
    .iCmdValid(cmd_valid), .oCmdReady(cmd_ready),
    .iCmdOp(cmd_op), .iCmdA(cmd_a), .iCmdB(cmd_b),
    .oAluNibble1(alu_n1), .oAluNibble2(alu_n2), .oAluSelector(alu_sel),
    .iAluResult(alu_res),
    .oResValid(res_valid), .iResReady(res_ready),
    .oResult(result), .oResOp(res_op), .oResErr(res_err),
`ifdef ALU_SEQ_ZERO_FLAG_EN
    .oResZero(res_zero),
`endif
    .oBusy(busy), .oCount(count)
  );

  // Combinational 4-bit ALU attached to the sequencer.
  always_comb begin
    case (alu_sel)
      3'd0:    alu_res = alu_n1 + alu_n2;
      3'd1:    alu_res = alu_n1 - alu_n2;
      3'd2:    alu_res = alu_n1 & alu_n2;
      3'd3:    alu_res = alu_n1 | alu_n2;
      3'd4:    alu_res = alu_n1 ^ alu_n2;
      default: alu_res = 4'd0;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  // Reference model: what the result channel should return for a command.
  function automatic exp_t model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    int ia = int'(a);
    int ib = int'(b);
    int r;
    case (op)
      3'd0:    r = (ia + ib) % 16;
      3'd1:    r = (ia - ib + 16) % 16;
      3'd2:    r = int'(a & b);
      3'd3:    r = int'(a | b);
      3'd4:    r = int'(a ^ b);
      default: r = 0;
    endcase
    e.op  = op;
    e.res = 4'(r);
    e.err = (op > 3'd4);
    if (!e.err) begin
      mdl_a = a; mdl_b = b; mdl_sel = op;
    end
    e.sa = mdl_a; e.sb = mdl_b; e.ssel = mdl_sel;
    return e;
  endfunction

  // Present one command (called at posedge+1); leaves cmd_valid high on return.
  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int tries = 0;
    bit done = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    while (!done) begin
      @(negedge clk);
      if (cmd_ready) begin
        exp_q.push_back(model(op, a, b));
        done = 1;
      end
      @(posedge clk); #1;
      if (!done) begin
        tries++;
        if (tries > 200) begin
          chk("send_timeout", 0, 1);
          cmd_valid = 1'b0;
          done = 1;
        end
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_reached", int'(n < 1000), 1);
  endtask

  task automatic lat_test(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                          input int exp_lat, input string name);
    int lat = 1;
    bit seen = 0;
    res_ready = 1'b1;
    wait_idle();
    send(op, a, b);
    cmd_valid = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (res_valid) seen = 1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    chk(name, seen ? lat : -1, exp_lat);
    @(posedge clk); #1;
    wait_idle();
  endtask

  // Monitor: every completed result handshake is checked against the queue head.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("result", int'(result), int'(e.res));
        chk("res_op", int'(res_op), int'(e.op));
        chk("res_err", int'(res_err), int'(e.err));
        chk("alu_nibble1", int'(alu_n1), int'(e.sa));
        chk("alu_nibble2", int'(alu_n2), int'(e.sb));
        chk("alu_selector", int'(alu_sel), int'(e.ssel));
`ifdef ALU_SEQ_ZERO_FLAG_EN
        chk("res_zero", int'(res_zero), int'(e.res == 4'd0));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rnd_done = 0;
    rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_alu_n1", int'(alu_n1), 0);
    chk("rst_alu_sel", int'(alu_sel), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_res_err", int'(res_err), 0);
    @(posedge clk); #1;

    // Latency of a legal op (cycle 2+SETTLE) and of an illegal op (cycle 2)
    lat_test(3'd0, 4'd5, 4'd7, 2 + SETTLE, "lat_add");
    lat_test(3'd6, 4'd3, 4'd3, 2, "lat_illegal");

    // Back-to-back sub wrap, and, xor
    res_ready = 1'b1;
    send(3'd1, 4'd5, 4'hA);
    send(3'd2, 4'hC, 4'hA);
    send(3'd4, 4'hF, 4'h5);
    cmd_valid = 1'b0;
    wait_idle();

    // Fill with ready low: first result held, FIFO reaches full
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(3'($urandom_range(0, 4)), 4'($urandom), 4'($urandom));
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("full_count", int'(count), DEPTH);
    chk("full_cmd_ready", int'(cmd_ready), 0);
    chk("full_res_valid", int'(res_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_valid", int'(res_valid), 1);
      chk("hold_result", int'(result), int'(exp_q[0].res));
      chk("hold_op", int'(res_op), int'(exp_q[0].op));
      chk("hold_no_pop", int'(count), DEPTH);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_idle();

    // Reset during DRIVE with two commands queued
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(3'd0, 4'(i + 1), 4'd2);
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_count", int'(count), 2);
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_valid", int'(res_valid), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    mdl_a = '0; mdl_b = '0; mdl_sel = '0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_count", int'(count), 0);
    chk("post_rst_valid", int'(res_valid), 0);
    chk("post_rst_alu_n1", int'(alu_n1), 0);
    chk("post_rst_alu_n2", int'(alu_n2), 0);
    chk("post_rst_alu_sel", int'(alu_sel), 0);
    chk("post_rst_ready", int'(cmd_ready), 1);
    repeat (20) @(posedge clk);
    #1 chk("post_rst_quiet", int'(busy), 0);

    // Randomized traffic with random result back-pressure
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          logic [2:0] op;
          op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
          send(op, 4'($urandom), 4'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            cmd_valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin
              @(posedge clk); #1;
            end
          end
        end
        cmd_valid = 1'b0;
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          res_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    res_ready = 1'b1;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
